mat_cache_seq: RTL and testbench

Command-driven sequencer in front of one `MatCache` instance. It turns a single load or store command into `WIDTH` back-to-back cache row, column or diagonal accesses. Each access steps `param` from 0 to `WIDTH-1`. Vector data moves over valid/ready streams, so the matrix unit's front end can fill or drain a whole tile without issuing per-vector cache ops.

---
 rtl/mat_cache_seq.sv | 133 +++++++++++++
 tb/tb_mat_cache_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_cache_seq.sv
// Command sequencer in front of a MatCache: expands one load/store command into
// WIDTH row/column/diagonal cache accesses, with vector data on valid/ready streams.
module mat_cache_seq #(
  parameter int WIDTH = 4,
  parameter int CACHE_SIZE = 4,
  localparam int AW = (CACHE_SIZE > 1) ? $clog2(CACHE_SIZE) : 1,
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [AW-1:0]           cmd_addr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0][31:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0][31:0]  out_data,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              read_op,
  output logic [AW-1:0]           read_addr1,
  output logic [AW-1:0]           read_addr2,
  output logic [CW-1:0]           read_param,
  output logic [1:0]              write_op,
  output logic [AW-1:0]           write_addr1,
  output logic [CW-1:0]           write_param,
  output logic [WIDTH-1:0][31:0]  data_in,
  input  logic [WIDTH-1:0][31:0]  data_out
);

  localparam logic [1:0] RD_NONE = 2'd0;
  localparam logic [1:0] RD_ROW  = 2'd1;
  localparam logic [1:0] RD_DIAG = 2'd3;
  localparam logic [1:0] WR_NONE = 2'd0;
  localparam logic [1:0] WR_ROW  = 2'd1;
  localparam logic [1:0] WR_COL  = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          done_q, done_d;
  logic          beat;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    addr_d      = addr_q;
    done_d      = 1'b0;
    beat        = 1'b0;
    cmd_ready   = 1'b0;
    busy        = 1'b1;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    read_op     = RD_NONE;
    read_addr1  = '0;
    read_addr2  = '0;
    read_param  = '0;
    write_op    = WR_NONE;
    write_addr1 = '0;
    write_param = '0;
    data_in     = in_data;
    out_data    = data_out;

    unique case (state_q)
      S_IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = cmd_op;
          addr_d  = cmd_addr;
          cnt_d   = '0;
          state_d = cmd_op[1] ? S_STORE : S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready    = 1'b1;
        write_addr1 = addr_q;
        write_param = cnt_q;
        // The cache captures the vector on the same edge as the handshake.
        if (in_valid) begin
          write_op = op_q[0] ? WR_COL : WR_ROW;
          beat     = 1'b1;
        end
      end
      S_STORE: begin
        out_valid  = 1'b1;
        read_op    = op_q[0] ? RD_DIAG : RD_ROW;
        read_addr1 = addr_q;
        read_addr2 = addr_q;
        read_param = cnt_q;
        beat       = out_ready;
      end
      default: state_d = S_IDLE;
    endcase

    if (beat) begin
      if (cnt_q == LAST) begin
        cnt_d   = '0;
        state_d = S_IDLE;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_mat_cache_seq.sv
// Bench for mat_cache_seq: behavioural MatCache beside the DUT, directed commands,
// and a negedge monitor that pops expected writes/reads/done pulses from queues.
module tb_mat_cache_seq;
  localparam int W = 4;
  localparam int CS = 4;
  localparam logic [1:0] WR_NONE = 2'd0, WR_ROW = 2'd1, WR_COL = 2'd2;
  localparam logic [1:0] RD_ROW = 2'd1, RD_DIAG = 2'd3;
  localparam logic [1:0] OP_LROW = 2'd0, OP_LCOL = 2'd1, OP_SROW = 2'd2, OP_SDIAG = 2'd3;

  typedef logic [W-1:0][31:0] vec_t;
  typedef struct { logic [1:0] op; logic [1:0] addr; logic [1:0] param; vec_t data; } wr_t;
  typedef struct { logic [1:0] addr; logic [1:0] param; vec_t data; } rd_t;

  logic clock = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_op = 2'd0, cmd_addr = 2'd0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy, done;
  vec_t in_data = '0, out_data, data_in, data_out;
  logic [1:0] read_op, read_addr1, read_addr2, read_param;
  logic [1:0] write_op, write_addr1, write_param;

  int checks = 0, failures = 0, cyc = 0;
  wr_t exp_wr[$];
  rd_t exp_rd[$];
  int  exp_done[$];
  wr_t mw;
  rd_t mr;
  vec_t load_v[W], exp_v[W];
  logic [31:0] mem [CS][W][W];

  mat_cache_seq #(.WIDTH(W), .CACHE_SIZE(CS)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .read_op(read_op), .read_addr1(read_addr1),
    .read_addr2(read_addr2), .read_param(read_param), .write_op(write_op),
    .write_addr1(write_addr1), .write_param(write_param), .data_in(data_in),
    .data_out(data_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // MatCache model: diagonal p holds element i from column (p - i) mod W.
  always @(posedge clock) begin
    for (int i = 0; i < W; i++) begin
      if (write_op == WR_ROW) mem[write_addr1][write_param][i] <= data_in[i];
      else if (write_op == WR_COL) mem[write_addr1][i][write_param] <= data_in[i];
    end
  end

  always_comb begin
    data_out = '0;
    for (int i = 0; i < W; i++) begin
      if (read_op == RD_ROW) data_out[i] = mem[read_addr1][read_param][i];
      else if (read_op == RD_DIAG) data_out[i] = mem[read_addr1][i][read_param - 2'(i)];
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic chk_v(string nm, vec_t act, vec_t req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] f2b(int n);
    int e = 0;
    if (n == 0) return 32'd0;
    while ((n >> (e + 1)) != 0) e++;
    return {1'b0, 8'(127 + e), 23'((n - (1 << e)) << (23 - e))};
  endfunction

  function automatic vec_t mk(int a, int b, int c, int d);
    vec_t v;
    v[0] = f2b(a); v[1] = f2b(b); v[2] = f2b(c); v[3] = f2b(d);
    return v;
  endfunction

  // Monitor: every write, store beat and done pulse must match the queue head.
  always @(negedge clock) begin
    if (!reset) begin
      if (write_op !== WR_NONE) begin
        if (exp_wr.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write: got op=%0d param=%0d required no write", write_op, write_param);
        end else begin
          mw = exp_wr.pop_front();
          $display("write op=%0d tile=%0d param=%0d data=%h", write_op, write_addr1, write_param, data_in);
          chk("wr_op", 32'(write_op), 32'(mw.op));
          chk("wr_addr", 32'(write_addr1), 32'(mw.addr));
          chk("wr_param", 32'(write_param), 32'(mw.param));
          chk_v("wr_data", data_in, mw.data);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        if (exp_rd.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_read: got param=%0d required no beat", read_param);
        end else begin
          mr = exp_rd.pop_front();
          $display("read op=%0d tile=%0d param=%0d data=%h", read_op, read_addr1, read_param, out_data);
          chk("rd_addr1", 32'(read_addr1), 32'(mr.addr));
          chk("rd_addr2", 32'(read_addr2), 32'(mr.addr));
          chk("rd_param", 32'(read_param), 32'(mr.param));
          chk_v("rd_data", out_data, mr.data);
        end
      end
      if (done === 1'b1) begin
        if (exp_done.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done: got done at cycle %0d required none", cyc);
        end else begin
          $display("done at cycle %0d", cyc);
          chk("done_cycle", cyc, exp_done.pop_front());
        end
      end
    end
  end

  // Presents a command from posedge+1 and returns at posedge+1 of the first busy cycle.
  task automatic issue(logic [1:0] op, logic [1:0] addr, output int acc);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; acc = -1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clock);
      if (cmd_ready) begin acc = cyc; break; end
    end
    if (acc < 0) begin
      checks++; failures++;
      $display("FAIL cmd_accept_timeout: got no cmd_ready in 50 cycles required accept");
    end
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic load_data(logic [1:0] op, logic [1:0] addr, int nbeats, bit toggle);
    for (int k = 0; k < nbeats; k++) begin
      exp_wr.push_back('{op: (op == OP_LCOL) ? WR_COL : WR_ROW, addr: addr, param: 2'(k), data: load_v[k]});
      in_valid = 1'b1; in_data = load_v[k];
      @(posedge clock); #1;
      if (toggle && k < W - 1) begin
        in_valid = 1'b0; in_data = {W{32'hdeadbeef}};
        @(posedge clock); #1;
      end
    end
    in_valid = 1'b0; in_data = {W{32'hdeadbeef}};
  endtask

  task automatic store_data(logic [1:0] addr, int stall_beat, int stall_len);
    for (int k = 0; k < W; k++) begin
      if (k == stall_beat) begin
        for (int s = 0; s < stall_len; s++) begin
          out_ready = 1'b0;
          @(negedge clock);
          chk_v("stall_data", out_data, exp_v[k]);
          chk("stall_param", 32'(read_param), k);
          @(posedge clock); #1;
        end
      end
      exp_rd.push_back('{addr: addr, param: 2'(k), data: exp_v[k]});
      out_ready = 1'b1;
      @(posedge clock); #1;
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, rc;
    in_data = {W{32'hdeadbeef}};
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_read_op", 32'(read_op), 0);
    chk("rst_write_op", 32'(write_op), 0);
    chk("rst_addrs", 32'({read_addr1, read_addr2, write_addr1}), 0);
    chk("rst_params", 32'({read_param, write_param}), 0);
    @(posedge clock); #1;

    // LOAD_ROW tile 0 at full rate, then STORE_DIAG tile 0.
    load_v = '{mk(4,6,1,6), mk(1,2,3,4), mk(3,3,3,3), mk(9,7,5,3)};
    issue(OP_LROW, 2'd0, a1);
    exp_done.push_back(a1 + W + 1);
    load_data(OP_LROW, 2'd0, W, 1'b0);
    exp_v = '{mk(4,4,3,7), mk(6,1,3,5), mk(1,2,3,3), mk(6,3,3,9)};
    issue(OP_SDIAG, 2'd0, a1);
    exp_done.push_back(a1 + W + 1);
    store_data(2'd0, -1, 0);

    // LOAD_COL tile 2 with in_valid toggling, then STORE_ROW tile 2 stalled on beat 1.
    load_v = '{mk(1,2,3,4), mk(5,6,7,8), mk(9,10,11,12), mk(13,14,15,16)};
    issue(OP_LCOL, 2'd2, a1);
    exp_done.push_back(a1 + W + 1 + (W - 1));
    load_data(OP_LCOL, 2'd2, W, 1'b1);
    exp_v = '{mk(1,5,9,13), mk(2,6,10,14), mk(3,7,11,15), mk(4,8,12,16)};
    issue(OP_SROW, 2'd2, a1);
    exp_done.push_back(a1 + W + 1 + 3);
    store_data(2'd2, 1, 3);

    // STORE_ROW tile 0 while a LOAD_ROW tile 3 is held waiting.
    exp_v = '{mk(4,6,1,6), mk(1,2,3,4), mk(3,3,3,3), mk(9,7,5,3)};
    issue(OP_SROW, 2'd0, a1);
    exp_done.push_back(a1 + W + 1);
    fork
      store_data(2'd0, -1, 0);
      issue(OP_LROW, 2'd3, a2);
    join
    chk("busy_accept_cycle", a2, a1 + W + 1);
    load_v = '{mk(2,4,8,16), mk(3,5,7,11), mk(10,20,30,40), mk(1,1,2,2)};
    exp_done.push_back(a2 + W + 1);
    fork
      load_data(OP_LROW, 2'd3, W, 1'b0);
      begin
        @(negedge clock);
        chk("start_busy", 32'(busy), 1);
        chk("start_in_ready", 32'(in_ready), 1);
      end
    join

    // Reset after two beats of a load; the next command goes in right away.
    load_v = '{mk(21,22,23,24), mk(25,26,27,28), mk(0,0,0,0), mk(0,0,0,0)};
    issue(OP_LROW, 2'd3, a1);
    load_data(OP_LROW, 2'd3, 2, 1'b0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    rc = cyc;
    load_v = '{mk(17,18,19,20), mk(31,32,33,34), mk(50,60,70,80), mk(99,98,97,96)};
    fork
      issue(OP_LROW, 2'd1, a1);
      begin
        @(negedge clock);
        chk("postrst_busy", 32'(busy), 0);
        chk("postrst_write_op", 32'(write_op), 0);
        chk("postrst_done", 32'(done), 0);
        chk("postrst_cmd_ready", 32'(cmd_ready), 1);
      end
    join
    chk("postrst_accept_cycle", a1, rc);

    // Back-to-back LOAD_ROW / STORE_ROW on tile 1 at full rate.
    exp_done.push_back(a1 + W + 1);
    load_data(OP_LROW, 2'd1, W, 1'b0);
    exp_v = load_v;
    issue(OP_SROW, 2'd1, a2);
    chk("cmd_spacing", a2 - a1, W + 1);
    exp_done.push_back(a2 + W + 1);
    store_data(2'd1, -1, 0);

    repeat (3) @(posedge clock);
    #1;
    chk("pending_writes", exp_wr.size(), 0);
    chk("pending_reads", exp_rd.size(), 0);
    chk("pending_done", exp_done.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
